// File: rtl/ecc_154_ctrl_if.sv
// Checker-side bus of ecc_154_ctrl: input-mux/stimulus/control toward the SECDED checker
// (master = controller) and the checker's same-cycle responses back (slave = checker).
interface ecc_154_ctrl_if #(
  parameter int DATA_WIDTH   = 154,
  parameter int PARITY_WIDTH = 9
);
  logic                    chk_sel;
  logic [DATA_WIDTH-1:0]   tst_data;
  logic [PARITY_WIDTH-1:0] tst_parity;
  logic                    ecc_bypass;
  logic                    ecc_fault_detc_en;
  logic                    chk_sbit_err;
  logic                    chk_dbit_err;
  logic                    chk_ecc_fault;

  modport master (
    output chk_sel, tst_data, tst_parity, ecc_bypass, ecc_fault_detc_en,
    input  chk_sbit_err, chk_dbit_err, chk_ecc_fault
  );

  modport slave (
    input  chk_sel, tst_data, tst_parity, ecc_bypass, ecc_fault_detc_en,
    output chk_sbit_err, chk_dbit_err, chk_ecc_fault
  );
endinterface

// File: rtl/ecc_154_ctrl.sv
// SECDED checker controller: periodic self-test slotted into the read path, sticky status, error counters.
// Optional macro ECC_154_CTRL_ERR_CNT_EN implements the functional error counters (tied to 0 otherwise).
module ecc_154_ctrl #(
  parameter int DATA_WIDTH   = 154,
  parameter int PARITY_WIDTH = 9,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_ecc_en,
  input  logic                 cfg_detc_en,
  input  logic [15:0]          cfg_test_period,
  input  logic                 rd_vld,
  output logic                 rd_stall,
  ecc_154_ctrl_if.master       chk,
  input  logic                 sts_clr,
  output logic [CNT_WIDTH-1:0] sbit_cnt,
  output logic [CNT_WIDTH-1:0] dbit_cnt,
  output logic [CNT_WIDTH-1:0] fault_cnt,
  output logic [15:0]          test_cnt,
  output logic                 st_fail,
  output logic [1:0]           fail_step,
  output logic                 irq
);

  localparam int KW = $clog2(DATA_WIDTH);
  localparam logic [KW-1:0] K_LAST = KW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PEND    = 3'd1,
    S_T_CLEAN = 3'd2,
    S_T_SBIT  = 3'd3,
    S_T_DBIT  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                  state_r;
  logic [15:0]             timer_r;
  logic [3:0]              wait_r;
  logic [KW-1:0]           k_r;
  logic                    sel_r;
  logic                    bypass_r;
  logic                    detc_r;
  logic [DATA_WIDTH-1:0]   tst_data_r;
  logic [15:0]             test_cnt_r;

  logic                    st_fail_r;
  logic [1:0]              fail_step_r;
  logic                    func_fault_r;
  logic                    irq_r;

  logic                    exp_sbit_s;
  logic                    exp_dbit_s;
  logic [1:0]              step_s;
  logic                    mismatch_s;
  logic                    func_rd_s;
  logic                    st_fail_nxt_s;
  logic [1:0]              fail_step_nxt_s;
  logic                    func_fault_nxt_s;

  function automatic logic [KW-1:0] k_next(input logic [KW-1:0] k);
    return (k == K_LAST) ? {KW{1'b0}} : k + {{(KW-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sbit_pattern(input logic [KW-1:0] k);
    return DATA_ONE << k;
  endfunction

  // Two adjacent bits, the upper one wrapping to bit 0 at the top of the word
  function automatic logic [DATA_WIDTH-1:0] dbit_pattern(input logic [KW-1:0] k);
    return (DATA_ONE << k) | (DATA_ONE << k_next(k));
  endfunction

  // Self-test sequencer with registered checker-mux controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      timer_r    <= 16'd0;
      wait_r     <= 4'd0;
      k_r        <= {KW{1'b0}};
      sel_r      <= 1'b0;
      bypass_r   <= 1'b1;
      detc_r     <= 1'b0;
      tst_data_r <= {DATA_WIDTH{1'b0}};
      test_cnt_r <= 16'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          bypass_r <= ~cfg_ecc_en;
          detc_r   <= cfg_detc_en;
          if (cfg_test_period == 16'd0) begin
            timer_r <= 16'd0;
          end else if (timer_r == cfg_test_period) begin
            timer_r <= 16'd0;
            state_r <= S_PEND;
          end else begin
            timer_r <= timer_r + 16'd1;
          end
        end
        S_PEND: begin
          if (!rd_vld || wait_r == 4'd15) begin
            wait_r     <= 4'd0;
            state_r    <= S_T_CLEAN;
            sel_r      <= 1'b1;
            bypass_r   <= 1'b0;
            detc_r     <= 1'b1;
            tst_data_r <= {DATA_WIDTH{1'b0}};
          end else begin
            wait_r   <= wait_r + 4'd1;
            bypass_r <= ~cfg_ecc_en;
            detc_r   <= cfg_detc_en;
          end
        end
        S_T_CLEAN: begin
          state_r    <= S_T_SBIT;
          tst_data_r <= sbit_pattern(k_r);
        end
        S_T_SBIT: begin
          state_r    <= S_T_DBIT;
          tst_data_r <= dbit_pattern(k_r);
        end
        S_T_DBIT: begin
          state_r    <= S_DONE;
          sel_r      <= 1'b0;
          bypass_r   <= ~cfg_ecc_en;
          detc_r     <= cfg_detc_en;
          tst_data_r <= {DATA_WIDTH{1'b0}};
        end
        S_DONE: begin
          state_r    <= S_IDLE;
          test_cnt_r <= test_cnt_r + 16'd1;
          k_r        <= k_next(k_r);
          bypass_r   <= ~cfg_ecc_en;
          detc_r     <= cfg_detc_en;
        end
        default: begin
          state_r    <= S_IDLE;
          sel_r      <= 1'b0;
          bypass_r   <= ~cfg_ecc_en;
          detc_r     <= cfg_detc_en;
          tst_data_r <= {DATA_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // Expected checker response for the current test step
  always_comb begin
    exp_sbit_s = 1'b0;
    exp_dbit_s = 1'b0;
    step_s     = 2'd0;
    case (state_r)
      S_T_CLEAN: step_s = 2'd1;
      S_T_SBIT: begin
        exp_sbit_s = 1'b1;
        step_s     = 2'd2;
      end
      S_T_DBIT: begin
        exp_dbit_s = 1'b1;
        step_s     = 2'd3;
      end
      default: begin
        exp_sbit_s = 1'b0;
        exp_dbit_s = 1'b0;
        step_s     = 2'd0;
      end
    endcase
  end

  assign mismatch_s = sel_r & ((chk.chk_sbit_err != exp_sbit_s) |
                               (chk.chk_dbit_err != exp_dbit_s) | chk.chk_ecc_fault);
  assign func_rd_s  = rd_vld & ~sel_r;

  // Sticky next-state: a fresh set wins over a same-cycle clear
  always_comb begin
    st_fail_nxt_s    = mismatch_s | (st_fail_r & ~sts_clr);
    func_fault_nxt_s = (func_rd_s & chk.chk_ecc_fault) | (func_fault_r & ~sts_clr);
    if (mismatch_s && (!st_fail_r || sts_clr)) begin
      fail_step_nxt_s = step_s;
    end else if (sts_clr) begin
      fail_step_nxt_s = 2'd0;
    end else begin
      fail_step_nxt_s = fail_step_r;
    end
  end

  // Sticky status and interrupt registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_fail_r    <= 1'b0;
      fail_step_r  <= 2'd0;
      func_fault_r <= 1'b0;
      irq_r        <= 1'b0;
    end else begin
      st_fail_r    <= st_fail_nxt_s;
      fail_step_r  <= fail_step_nxt_s;
      func_fault_r <= func_fault_nxt_s;
      irq_r        <= st_fail_nxt_s | func_fault_nxt_s;
    end
  end

`ifdef ECC_154_CTRL_ERR_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  logic [CNT_WIDTH-1:0] sbit_cnt_r;
  logic [CNT_WIDTH-1:0] dbit_cnt_r;
  logic [CNT_WIDTH-1:0] fault_cnt_r;

  function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic inc, input logic clr);
    if (clr) begin
      return inc ? CNT_ONE : CNT_ZERO;
    end else if (inc && cnt != CNT_MAX) begin
      return cnt + CNT_ONE;
    end else begin
      return cnt;
    end
  endfunction

  // Saturating functional error counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbit_cnt_r  <= CNT_ZERO;
      dbit_cnt_r  <= CNT_ZERO;
      fault_cnt_r <= CNT_ZERO;
    end else begin
      sbit_cnt_r  <= cnt_next(sbit_cnt_r,  func_rd_s & chk.chk_sbit_err,  sts_clr);
      dbit_cnt_r  <= cnt_next(dbit_cnt_r,  func_rd_s & chk.chk_dbit_err,  sts_clr);
      fault_cnt_r <= cnt_next(fault_cnt_r, func_rd_s & chk.chk_ecc_fault, sts_clr);
    end
  end

  assign sbit_cnt  = sbit_cnt_r;
  assign dbit_cnt  = dbit_cnt_r;
  assign fault_cnt = fault_cnt_r;
`else
  assign sbit_cnt  = {CNT_WIDTH{1'b0}};
  assign dbit_cnt  = {CNT_WIDTH{1'b0}};
  assign fault_cnt = {CNT_WIDTH{1'b0}};
`endif

  assign rd_stall              = sel_r;
  assign chk.chk_sel           = sel_r;
  assign chk.tst_data          = tst_data_r;
  assign chk.tst_parity        = {PARITY_WIDTH{1'b0}};
  assign chk.ecc_bypass        = bypass_r;
  assign chk.ecc_fault_detc_en = detc_r;
  assign test_cnt              = test_cnt_r;
  assign st_fail               = st_fail_r;
  assign fail_step             = fail_step_r;
  assign irq                   = irq_r;

endmodule

// File: tb/tb_ecc_154_ctrl.sv
// Scoreboard bench for ecc_154_ctrl: random read traffic, ideal checker model, queued expectations.
module tb_ecc_154_ctrl;
  localparam int DW = 154;
  localparam int PW = 9;
  localparam int CW = 16;
`ifdef ECC_154_CTRL_ERR_CNT_EN
  localparam int SAT_EXP = 65535;
  localparam int CLR_EXP = 1;
`else
  localparam int SAT_EXP = 0;
  localparam int CLR_EXP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_ecc_en = 1'b1;
  logic          cfg_detc_en = 1'b1;
  logic [15:0]   cfg_test_period = 16'd10;
  logic          rd_vld = 1'b0;
  logic          sts_clr = 1'b0;
  logic          rd_stall;
  logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;
  logic [15:0]   test_cnt;
  logic          st_fail;
  logic [1:0]    fail_step;
  logic          irq;

  logic f_sbit = 1'b0, f_dbit = 1'b0, f_fault = 1'b0;
  logic inj_sbit_zero = 1'b0, inj_dbit_zero = 1'b0;
  logic sb_s, db_s, ft_s;

  int errors = 0;
  int checks = 0;

  ecc_154_ctrl_if #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW)) chk_if ();

  ecc_154_ctrl #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_ecc_en(cfg_ecc_en), .cfg_detc_en(cfg_detc_en),
    .cfg_test_period(cfg_test_period), .rd_vld(rd_vld), .rd_stall(rd_stall), .chk(chk_if),
    .sts_clr(sts_clr), .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt),
    .test_cnt(test_cnt), .st_fail(st_fail), .fail_step(fail_step), .irq(irq)
  );

  always #5 clk = ~clk;

  // Ideal checker: weight of the presented word decides the flags; functional flags otherwise
  always_comb begin
    sb_s = f_sbit;
    db_s = f_dbit;
    ft_s = f_fault;
    if (chk_if.chk_sel) begin
      sb_s = (($countones(chk_if.tst_data) + $countones(chk_if.tst_parity)) == 1) && !inj_sbit_zero;
      db_s = (($countones(chk_if.tst_data) + $countones(chk_if.tst_parity)) == 2) && !inj_dbit_zero;
      ft_s = 1'b0;
    end
  end
  assign chk_if.chk_sbit_err  = sb_s;
  assign chk_if.chk_dbit_err  = db_s;
  assign chk_if.chk_ecc_fault = ft_s;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  typedef struct {
    logic          stall;
    logic [DW-1:0] data;
    logic          byp;
    logic          detc;
    logic [CW-1:0] sb, db, ft;
    logic [15:0]   tc;
    logic          stf;
    logic [1:0]    step;
    logic          irq;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: phase 0 idle, 1 waiting for a slot, 2..4 test steps, 5 wrap-up
  int m_ph, m_timer, m_wait, m_k, m_tc, m_sb, m_db, m_ft, m_step;
  bit m_stf, m_ff;

  function automatic int bump(int cnt, bit inc, bit clr);
    if (clr) return inc ? 1 : 0;
    if (inc && cnt < 65535) return cnt + 1;
    return cnt;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_timer = 0; m_wait = 0; m_k = 0; m_tc = 0;
    m_sb = 0; m_db = 0; m_ft = 0; m_step = 0; m_stf = 0; m_ff = 0;
  endtask

  task automatic model_step();
    exp_t e;
    bit in_test, func, mis;
    in_test = (m_ph >= 2 && m_ph <= 4);
    func    = rd_vld && !in_test;
    mis     = (m_ph == 3 && inj_sbit_zero) || (m_ph == 4 && inj_dbit_zero);
    if (mis && (!m_stf || sts_clr)) m_step = m_ph - 1;
    else if (sts_clr) m_step = 0;
    m_stf = mis || (m_stf && !sts_clr);
    m_ff  = (func && f_fault) || (m_ff && !sts_clr);
`ifdef ECC_154_CTRL_ERR_CNT_EN
    m_sb = bump(m_sb, func && f_sbit, sts_clr);
    m_db = bump(m_db, func && f_dbit, sts_clr);
    m_ft = bump(m_ft, func && f_fault, sts_clr);
`endif
    case (m_ph)
      0: begin
        if (cfg_test_period == 16'd0) m_timer = 0;
        else if (m_timer == int'(cfg_test_period)) begin m_timer = 0; m_ph = 1; end
        else m_timer = (m_timer + 1) % 65536;
      end
      1: begin
        if (!rd_vld || m_wait == 15) begin m_wait = 0; m_ph = 2; end
        else m_wait++;
      end
      5: begin m_tc = (m_tc + 1) % 65536; m_k = (m_k + 1) % DW; m_ph = 0; end
      default: m_ph++;
    endcase
    e.stall = (m_ph >= 2 && m_ph <= 4);
    e.data  = '0;
    if (m_ph >= 3) e.data[m_k] = 1'b1;
    if (m_ph == 4) e.data[(m_k + 1) % DW] = 1'b1;
    e.byp  = e.stall ? 1'b0 : !cfg_ecc_en;
    e.detc = e.stall ? 1'b1 : cfg_detc_en;
    e.sb = CW'(m_sb); e.db = CW'(m_db); e.ft = CW'(m_ft);
    e.tc = 16'(m_tc); e.stf = m_stf; e.step = 2'(m_step); e.irq = m_stf || m_ff;
    sb_q.push_back(e);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin model_reset(); sb_q.delete(); end
      else model_step();
    end
  end

  // Monitor: pops one expectation per cycle on the falling edge
  exp_t mon_e;
  initial forever begin
    @(negedge clk);
    if (rst_n && sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("rd_stall", DW'(rd_stall), DW'(mon_e.stall));
      chk("chk_sel", DW'(chk_if.chk_sel), DW'(mon_e.stall));
      if (mon_e.stall) chk("tst_data", chk_if.tst_data, mon_e.data);
      chk("tst_parity", DW'(chk_if.tst_parity), DW'(1'b0));
      chk("ecc_bypass", DW'(chk_if.ecc_bypass), DW'(mon_e.byp));
      chk("detc_en", DW'(chk_if.ecc_fault_detc_en), DW'(mon_e.detc));
      chk("sbit_cnt", DW'(sbit_cnt), DW'(mon_e.sb));
      chk("dbit_cnt", DW'(dbit_cnt), DW'(mon_e.db));
      chk("fault_cnt", DW'(fault_cnt), DW'(mon_e.ft));
      chk("test_cnt", DW'(test_cnt), DW'(mon_e.tc));
      chk("st_fail", DW'(st_fail), DW'(mon_e.stf));
      chk("fail_step", DW'(fail_step), DW'(mon_e.step));
      chk("irq", DW'(irq), DW'(mon_e.irq));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    rd_vld = 1'b0; f_sbit = 1'b0; f_dbit = 1'b0; f_fault = 1'b0; sts_clr = 1'b0;
  endtask

  // Period 0 with no traffic: any in-flight test completes and the timer returns to 0
  task automatic drain();
    quiet();
    cfg_test_period = 16'd0;
    repeat (30) tick();
  endtask

  initial begin
    int first_stall;
    bit found;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_ecc_bypass", DW'(chk_if.ecc_bypass), DW'(1'b1));
    chk("rst_detc_en", DW'(chk_if.ecc_fault_detc_en), DW'(1'b0));
    chk("rst_chk_sel", DW'(chk_if.chk_sel), DW'(1'b0));
    chk("rst_rd_stall", DW'(rd_stall), DW'(1'b0));
    chk("rst_test_cnt", DW'(test_cnt), DW'(0));
    chk("rst_sbit_cnt", DW'(sbit_cnt), DW'(0));
    chk("rst_st_fail", DW'(st_fail), DW'(1'b0));
    chk("rst_fail_step", DW'(fail_step), DW'(0));
    chk("rst_irq", DW'(irq), DW'(1'b0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Period 10, idle bus: slot at cycle 11, stalls from cycle 12
    first_stall = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (rd_stall && first_stall == 0) first_stall = c;
    end
    chk("first_stall_cycle", DW'(first_stall), DW'(12));

    // Continuous reads force the slot after 16 waiting cycles
    for (int c = 0; c < 150; c++) begin
      tick();
      rd_vld  = 1'b1;
      f_sbit  = ($urandom_range(0, 3) == 0);
      f_dbit  = ($urandom_range(0, 5) == 0);
      f_fault = ($urandom_range(0, 15) == 0);
    end

    // Random traffic, clears and configuration changes
    for (int c = 0; c < 3000; c++) begin
      tick();
      rd_vld  = ($urandom_range(0, 3) != 0);
      f_sbit  = ($urandom_range(0, 7) == 0);
      f_dbit  = ($urandom_range(0, 9) == 0);
      f_fault = ($urandom_range(0, 31) == 0);
      sts_clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) cfg_ecc_en = ~cfg_ecc_en;
      if ($urandom_range(0, 99) == 0) cfg_detc_en = ~cfg_detc_en;
      if ($urandom_range(0, 399) == 0) cfg_test_period = 16'($urandom_range(0, 30));
    end

    // Broken single-bit detection, then broken double-bit detection
    drain();
    sts_clr = 1'b1;
    tick();
    sts_clr = 1'b0;
    cfg_test_period = 16'd5;
    inj_sbit_zero = 1'b1;
    repeat (40) tick();
    chk("inj_st_fail", DW'(st_fail), DW'(1'b1));
    chk("inj_fail_step", DW'(fail_step), DW'(2));
    chk("inj_irq", DW'(irq), DW'(1'b1));
    inj_sbit_zero = 1'b0;
    inj_dbit_zero = 1'b1;
    repeat (40) tick();
    chk("dbit_keeps_step", DW'(fail_step), DW'(2));
    inj_dbit_zero = 1'b0;

    // Walk k around the whole word
    drain();
    cfg_test_period = 16'd1;
    repeat (1100) tick();

    // Functional fault raises irq; a quiet clear drops it
    drain();
    sts_clr = 1'b1;
    tick();
    sts_clr = 1'b0;
    tick();
    rd_vld = 1'b1; f_fault = 1'b1;
    tick();
    chk("fault_irq", DW'(irq), DW'(1'b1));
    rd_vld = 1'b0; f_fault = 1'b0;
    tick();
    sts_clr = 1'b1;
    tick();
    sts_clr = 1'b0;
    chk("clr_irq", DW'(irq), DW'(1'b0));

    // Saturation, then a clear coinciding with a new single-bit error
    rd_vld = 1'b1; f_sbit = 1'b1;
    repeat (65540) tick();
    chk("sbit_sat", DW'(sbit_cnt), DW'(SAT_EXP));
    sts_clr = 1'b1;
    tick();
    chk("sbit_clr_inc", DW'(sbit_cnt), DW'(CLR_EXP));
    quiet();

    // Reset during the single-bit step
    drain();
    cfg_test_period = 16'd3;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk);
      #1;
      if (m_ph == 3) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL reset_wait: T_SBIT not reached within 100 cycles");
    end else begin
      chk("pre_rst_chk_sel", DW'(chk_if.chk_sel), DW'(1'b1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_chk_sel", DW'(chk_if.chk_sel), DW'(1'b0));
      chk("mid_rst_rd_stall", DW'(rd_stall), DW'(1'b0));
      chk("mid_rst_test_cnt", DW'(test_cnt), DW'(0));
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      first_stall = 0;
      for (int c = 1; c <= 30; c++) begin
        tick();
        if (rd_stall && first_stall == 0) first_stall = c;
      end
      chk("post_rst_stall_cycle", DW'(first_stall), DW'(5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ecc_154_ctrl.md
# ecc_154_ctrl

Controller for the 154-bit SECDED checker with duplicated-decoder fault detection. Owns the checker's `bypass` and `ecc_fault_detc_en` controls and shares the checker's inputs between functional read traffic and a periodic built-in self-test. The self-test drives known codewords (clean, single-flip, double-flip) and checks the `sbit_err`, `dbit_err` and `ecc_fault` responses. Sits beside the checker in the FIFO read path and accumulates functional error statistics and sticky status for software.

## Interface
- DATA_WIDTH, 154, checker data width
- PARITY_WIDTH, 9, checker parity width
- CNT_WIDTH, 16, width of each error counter
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_ecc_en  in  1  1 = correction active; functional `ecc_bypass` = ~cfg_ecc_en
- cfg_detc_en  in  1  enables duplicated-decoder fault detection
- cfg_test_period  in  16  idle cycles between self-tests; 0 = self-test disabled
- rd_vld  in  1  functional read word presented to the checker this cycle
- rd_stall  out  1  upstream must hold its read word; not accepted this cycle
- chk_sel  out  1  1 = checker inputs taken from tst_data/tst_parity
- tst_data  out  DATA_WIDTH  self-test stimulus data
- tst_parity  out  PARITY_WIDTH  self-test stimulus parity (always 0)
- ecc_bypass  out  1  to checker `bypass`
- ecc_fault_detc_en  out  1  to checker
- chk_sbit_err, chk_dbit_err, chk_ecc_fault  in  1 each  checker responses (combinational, same cycle)
- sts_clr  in  1  pulse: clear sticky status and counters
- sbit_cnt, dbit_cnt, fault_cnt  out  CNT_WIDTH each  functional error counts
- test_cnt  out  16  completed self-tests, wraps
- st_fail  out  1  sticky self-test mismatch
- fail_step  out  2  step of the first mismatch: 1 clean, 2 sbit, 3 dbit
- irq  out  1  st_fail | sticky functional ecc_fault

## Operation
- States: IDLE, PEND, T_CLEAN, T_SBIT, T_DBIT, DONE.
- IDLE: period timer increments each cycle. When `cfg_test_period != 0` and timer == `cfg_test_period`, clear the timer and go to PEND. A period of 0 holds the timer at 0.
- PEND: go to T_CLEAN in the cycle after a PEND cycle with `rd_vld == 0`. Otherwise increment wait_cnt; when wait_cnt == 15, go to T_CLEAN regardless of `rd_vld` (forced slot).
- Test states: each lasts one cycle.
  - Decoded from the state register: `rd_stall = chk_sel = 1`, `ecc_bypass = 0`, `ecc_fault_detc_en = 1`.
  - T_CLEAN: tst_data = 0. Expect sbit 0, dbit 0.
  - T_SBIT: tst_data = bit k set. Expect sbit 1, dbit 0.
  - T_DBIT: tst_data = bits k and (k+1) mod DATA_WIDTH set. Expect sbit 0, dbit 1.
  - Every step also expects fault 0. The all-zero word with parity 0 is a valid codeword.
- Mismatch handling: set st_fail. If st_fail was already 0, latch fail_step.
- DONE: test_cnt+1. k increments, wrapping DATA_WIDTH-1→0. Return to IDLE.
- Outside test states: `chk_sel = rd_stall = 0`, `ecc_bypass = ~cfg_ecc_en`, `ecc_fault_detc_en = cfg_detc_en`.
- Functional accounting, only when `rd_vld & ~chk_sel`:
  - sbit_cnt, dbit_cnt and fault_cnt each increment on their flag.
  - Counters saturate at all-ones.
  - chk_ecc_fault also sets the sticky func_fault.
- sts_clr clears st_fail, fail_step, func_fault and the three counters. In the same cycle, a new set or increment takes priority: the counter loads 1 and the sticky bit stays 1.

## Timing
- Reset: all outputs 0 except `ecc_bypass = 1` (cfg not yet sampled) and `ecc_fault_detc_en = 0`. State IDLE, timer 0, wait_cnt 0, k 0.
- Reset asserted mid-test drops chk_sel/rd_stall immediately (asynchronously). The partial test is discarded and test_cnt is not incremented.
- Self-test occupancy: exactly 3 stalled cycles (T_CLEAN..T_DBIT), plus 1 DONE cycle without stall.
- Worst-case functional delay: 3 cycles stalled after a 16-cycle PEND wait.
- Status, counter and irq updates are registered: visible one cycle after the sampled cycle.
- Changing cfg_test_period mid-count takes effect at the next timer compare.

## Configuration
- `ECC_154_CTRL_ERR_CNT_EN` defined: sbit_cnt, dbit_cnt and fault_cnt are implemented as specified.
- Not defined: the three counters are not instantiated and are tied to 0. Self-test, func_fault and irq are unaffected.

## Test plan
- Period 10, rd_vld=0, ideal checker model. Required: PEND at cycle 11, stall cycles 12-14, test_cnt=1, st_fail=0; k=1 after the first test and k=0 after 154 tests.
- rd_vld held 1 through PEND. Required: forced T_CLEAN after 16 PEND cycles; no counter increments during stall cycles.
- Model returns sbit=0 in T_SBIT. Required: st_fail=1, fail_step=2, irq=1. A later dbit mismatch leaves fail_step=2.
- Functional rd_vld with chk_sbit_err for 65540 cycles (CNT_WIDTH=16). Required: sbit_cnt saturates at 0xFFFF. sts_clr with a simultaneous sbit gives sbit_cnt=1.
- chk_ecc_fault on a functional read. Required: irq=1 next cycle. sts_clr in a quiet cycle gives irq=0.
- rst_n asserted during T_SBIT. Required: chk_sel=0 immediately, test_cnt=0, state IDLE after release.
